sdm_adc_framer: RTL and testbench

SDM_ADC_FRAMER -- requirements
Module: sdm_adc_framer

---
 rtl/sdm_adc_framer_pkg.sv | 23 ++
 rtl/sdm_adc_framer_fifo.sv | 57 +++++
 rtl/sdm_adc_framer.sv | 157 +++++++++++++++
 tb/tb_sdm_adc_framer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdm_adc_framer_pkg.sv
// Shared constants for the SDM/ADC framer: header layout and frame sizing.
package sdm_adc_framer_pkg;

  localparam int WORD_W    = 64;
  localparam int DATA_BITS = 63;

  localparam logic [6:0] HDR_SYNC         = 7'h5A;
  localparam int         HDR_SYNC_LSB     = 56;
  localparam int         HDR_SYNC_W       = 7;
  localparam int         HDR_MISALIGN_BIT = 55;
  localparam int         HDR_CNT_LSB      = 0;
  localparam int         HDR_CNT_W        = 32;
  localparam int         LAST_BIT         = 63;

  function automatic int payload_bits(int nch_adc, int adc_bits, int nch_sdm, int sdm_per_adc);
    return nch_adc * adc_bits + sdm_per_adc * nch_sdm * 2;
  endfunction

  function automatic int data_words(int p);
    return (p + DATA_BITS - 1) / DATA_BITS;
  endfunction

endpackage

// File: rtl/sdm_adc_framer_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy-derived flags.
module sdm_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 64
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   free
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the array has no reset; pointers and count define which entries are
  // valid, and resetting storage would prevent RAM inference.
  always_ff @(posedge CLK) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_L);
  assign free    = DEPTH_L - count;
  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/sdm_adc_framer.sv
// Frames one ADC sample vector plus a sliding window of SDM samples into a
// header + NW data words and streams them out through an FWFT FIFO.
module sdm_adc_framer
  import sdm_adc_framer_pkg::*;
#(
  parameter int NCH_ADC     = 20,
  parameter int ADC_BITS    = 16,
  parameter int NCH_SDM     = 19,
  parameter int SDM_PER_ADC = 5,
  parameter int FIFO_DEPTH  = 64
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          ENABLE,
  input  logic [NCH_ADC*ADC_BITS-1:0]   ADC_Q,
  input  logic                          ADC_Q_VALID,
  input  logic [NCH_SDM*2-1:0]          SDM_Q,
  input  logic                          SDM_Q_VALID,
  output logic [63:0]                   M_AXIS_TDATA,
  output logic                          M_AXIS_TVALID,
  output logic                          M_AXIS_TLAST,
  input  logic                          M_AXIS_TREADY,
  output logic [31:0]                   FRAME_CNT,
  output logic [15:0]                   DROP_CNT,
  output logic                          FIFO_FULL
);

  localparam int SDM_W  = NCH_SDM * 2;
  localparam int WIN_W  = SDM_PER_ADC * SDM_W;
  localparam int ADC_W  = NCH_ADC * ADC_BITS;
  localparam int P      = payload_bits(NCH_ADC, ADC_BITS, NCH_SDM, SDM_PER_ADC);
  localparam int NW     = data_words(P);
  localparam int PAD_W  = NW * DATA_BITS;
  localparam int CNT_W  = $clog2(SDM_PER_ADC + 1);
  localparam int IDX_W  = $clog2(NW + 1);
  localparam int FREE_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CNT_W-1:0]  CNT_MAX     = CNT_W'(SDM_PER_ADC);
  localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(NW - 1);
  localparam logic [FREE_W-1:0] FRAME_WORDS = FREE_W'(NW + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [WIN_W-1:0]  win;
  logic [WIN_W-1:0]  win_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic [1:0]        state;
  logic [IDX_W-1:0]  word_idx;
  logic [PAD_W-1:0]  payload;
  logic              misalign;
  logic [63:0]       hdr_word;
  logic              wr_valid;
  logic [63:0]       wr_data;
  logic [FREE_W-1:0] fifo_free;
  logic              fifo_empty;
  logic              fifo_at_full;
  logic              trigger;
  logic              accept;
  logic              drop;

  // NOTE: every variable assigned here gets a default first, so no path can
  // leave it holding its old value and infer a latch.
  always_comb begin
    win_next = win;
    cnt_next = cnt;
    if (SDM_Q_VALID) begin
      win_next = win >> SDM_W;
      win_next[WIN_W-1 -: SDM_W] = SDM_Q;
      if (cnt < CNT_MAX) cnt_next = cnt + 1'b1;
    end
  end

  always_comb begin
    hdr_word = '0;
    hdr_word[HDR_SYNC_LSB +: HDR_SYNC_W] = HDR_SYNC;
    hdr_word[HDR_MISALIGN_BIT]           = misalign;
    hdr_word[HDR_CNT_LSB +: HDR_CNT_W]   = FRAME_CNT;
  end

  // The word still sitting in the write register is not yet counted by the FIFO.
  assign trigger = ADC_Q_VALID && ENABLE;
  assign accept  = trigger && (state == ST_IDLE) && !fifo_at_full &&
                   (fifo_free >= FRAME_WORDS + FREE_W'(wr_valid));
  assign drop    = trigger && !accept;

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      win       <= '0;
      cnt       <= '0;
      state     <= ST_IDLE;
      word_idx  <= '0;
      payload   <= '0;
      misalign  <= 1'b0;
      wr_valid  <= 1'b0;
      wr_data   <= '0;
      FRAME_CNT <= '0;
      DROP_CNT  <= '0;
      FIFO_FULL <= 1'b0;
    end else begin
      win      <= win_next;
      cnt      <= ADC_Q_VALID ? '0 : cnt_next;
      wr_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            payload  <= PAD_W'({win_next, ADC_Q});
            misalign <= (cnt_next < CNT_MAX);
            state    <= ST_HDR;
          end
        end
        ST_HDR: begin
          wr_valid  <= 1'b1;
          wr_data   <= hdr_word;
          FRAME_CNT <= FRAME_CNT + 1'b1;
          word_idx  <= '0;
          state     <= ST_DATA;
        end
        ST_DATA: begin
          wr_valid <= 1'b1;
          wr_data  <= {(word_idx == LAST_IDX), payload[DATA_BITS-1:0]};
          payload  <= payload >> DATA_BITS;
          word_idx <= word_idx + 1'b1;
          if (word_idx == LAST_IDX) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      if (drop) begin
        FIFO_FULL <= 1'b1;
        if (DROP_CNT != 16'hFFFF) DROP_CNT <= DROP_CNT + 1'b1;
      end
    end
  end

  sdm_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RESET   (RESET),
    .wr_en   (wr_valid),
    .wr_data (wr_data),
    .rd_en   (M_AXIS_TREADY),
    .rd_data (M_AXIS_TDATA),
    .empty   (fifo_empty),
    .full    (fifo_at_full),
    .free    (fifo_free)
  );

  assign M_AXIS_TVALID = !fifo_empty;
  assign M_AXIS_TLAST  = M_AXIS_TDATA[LAST_BIT];

endmodule

// File: tb/tb_sdm_adc_framer.sv
// Directed bench for sdm_adc_framer with a queue-based frame model checked every cycle.
module tb_sdm_adc_framer;

  localparam int NW    = 9;
  localparam int DEPTH = 64;
  localparam int PADW  = 567;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          ENABLE;
  logic [319:0]  ADC_Q;
  logic          ADC_Q_VALID;
  logic [37:0]   SDM_Q;
  logic          SDM_Q_VALID;
  logic [63:0]   M_AXIS_TDATA;
  logic          M_AXIS_TVALID;
  logic          M_AXIS_TLAST;
  logic          M_AXIS_TREADY;
  logic [31:0]   FRAME_CNT;
  logic [15:0]   DROP_CNT;
  logic          FIFO_FULL;

  sdm_adc_framer dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .ENABLE        (ENABLE),
    .ADC_Q         (ADC_Q),
    .ADC_Q_VALID   (ADC_Q_VALID),
    .SDM_Q         (SDM_Q),
    .SDM_Q_VALID   (SDM_Q_VALID),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .FRAME_CNT     (FRAME_CNT),
    .DROP_CNT      (DROP_CNT),
    .FIFO_FULL     (FIFO_FULL)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: expected stream words with the negedge index at which each becomes visible.
  typedef struct {
    logic [63:0] data;
    int          vis;
  } exp_t;

  exp_t        q[$];
  logic [63:0] got[$];
  logic [37:0] mwin [5];
  int          mcnt;
  int          last_acc;
  int          ncyc     = 0;
  logic [31:0] mframe;
  logic [15:0] mdrop;
  logic        mfull;
  logic        model_on = 1'b0;

  always @(negedge CLK) begin
    logic             vis_ok;
    logic             mis;
    logic             acc;
    logic [PADW-1:0]  pay;
    logic [63:0]      hdr;
    vis_ok = (q.size() > 0) && (q[0].vis <= ncyc);
    if (model_on) begin
      check("tvalid", {63'd0, M_AXIS_TVALID}, {63'd0, vis_ok});
      if (vis_ok) begin
        check("tdata", M_AXIS_TDATA, q[0].data);
        check("tlast", {63'd0, M_AXIS_TLAST}, {63'd0, q[0].data[63]});
      end
      check("drop_cnt", {48'd0, DROP_CNT}, {48'd0, mdrop});
      check("fifo_full", {63'd0, FIFO_FULL}, {63'd0, mfull});
    end
    if (RESET) begin
      q.delete();
      for (int s = 0; s < 5; s++) mwin[s] = '0;
      mcnt     = 0;
      last_acc = -1000;
      mframe   = '0;
      mdrop    = '0;
      mfull    = 1'b0;
      model_on = 1'b1;
    end else begin
      acc = 1'b0;
      if (SDM_Q_VALID) begin
        for (int s = 0; s < 4; s++) mwin[s] = mwin[s+1];
        mwin[4] = SDM_Q;
        if (mcnt < 5) mcnt++;
      end
      if (ADC_Q_VALID) begin
        mis = (mcnt < 5);
        if (ENABLE) begin
          acc = (ncyc - last_acc >= NW + 2) && (DEPTH - q.size() >= NW + 1);
          if (!acc) begin
            mfull = 1'b1;
            if (mdrop != 16'hFFFF) mdrop++;
          end
        end
        mcnt = 0;
      end
      if (vis_ok && M_AXIS_TREADY) begin
        got.push_back(M_AXIS_TDATA);
        void'(q.pop_front());
      end
      if (acc) begin
        pay = '0;
        pay[319:0] = ADC_Q;
        for (int s = 0; s < 5; s++) pay[320 + 38*s +: 38] = mwin[s];
        hdr = {1'b0, 7'h5A, mis, 23'd0, mframe};
        q.push_back('{data: hdr, vis: ncyc + 3});
        for (int k = 0; k < NW; k++)
          q.push_back('{data: {(k == NW - 1), pay[63*k +: 63]}, vis: ncyc + 4 + k});
        mframe++;
        last_acc = ncyc;
      end
    end
    ncyc++;
  end

  localparam logic [37:0]  S1  = 38'h01_1111_1111;
  localparam logic [37:0]  S2  = 38'h02_2222_2222;
  localparam logic [37:0]  S3  = 38'h03_3333_3333;
  localparam logic [37:0]  S4  = 38'h04_4444_4444;
  localparam logic [37:0]  S5  = 38'h3F_0000_0005;
  localparam logic [319:0] ADC = {10{32'h1357_9BDF}};

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic sdm(input logic [37:0] v);
    SDM_Q = v;
    SDM_Q_VALID = 1'b1;
    tick();
    SDM_Q_VALID = 1'b0;
    tick();
  endtask

  task automatic adc_strobe();
    ADC_Q = ADC;
    ADC_Q_VALID = 1'b1;
    tick();
    ADC_Q_VALID = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick(2);
    RESET = 1'b0;
    got.delete();
  endtask

  task automatic five_sdm();
    sdm(S1); sdm(S2); sdm(S3); sdm(S4); sdm(S5);
  endtask

  function automatic logic [PADW-1:0] rebuild_payload();
    logic [PADW-1:0] p = '0;
    for (int k = 0; k < NW; k++)
      if (got.size() > k + 1) p[63*k +: 63] = got[k+1][62:0];
    return p;
  endfunction

  logic [PADW-1:0] pay_chk;

  initial begin
    RESET = 1'b1; ENABLE = 1'b1; ADC_Q = '0; ADC_Q_VALID = 1'b0;
    SDM_Q = '0; SDM_Q_VALID = 1'b0; M_AXIS_TREADY = 1'b1;
    tick(3);
    RESET = 1'b0;
    check("rst_tvalid", {63'd0, M_AXIS_TVALID}, 64'd0);
    check("rst_tdata", M_AXIS_TDATA, 64'd0);
    check("rst_tlast", {63'd0, M_AXIS_TLAST}, 64'd0);
    check("rst_frame_cnt", {32'd0, FRAME_CNT}, 64'd0);

    // Aligned frame, ready sink
    do_reset();
    five_sdm();
    adc_strobe();
    tick(30);
    check("t1_words", 64'(got.size()), 64'd10);
    check("t1_hdr", got[0], 64'h5A00_0000_0000_0000);
    check("t1_word1", got[1], 64'h1357_9BDF_1357_9BDF);
    check("t1_last", got[9], 64'h8000_0000_0000_003F);
    check("t1_frame_cnt", {32'd0, FRAME_CNT}, 64'd1);

    // Only three SDM samples: misaligned, oldest slots still zero
    do_reset();
    sdm(S1); sdm(S2); sdm(S3);
    adc_strobe();
    tick(30);
    check("t2_hdr", got[0], 64'h5A80_0000_0000_0000);
    pay_chk = rebuild_payload();
    check("t2_slots01", {52'd0, pay_chk[320 +: 76] != 76'd0}, 64'd0);
    check("t2_slot2", {26'd0, pay_chk[396 +: 38]}, {26'd0, S1});

    // SDM strobe coincident with ADC strobe lands in slot 4
    do_reset();
    sdm(S1); sdm(S2); sdm(S3); sdm(S4);
    SDM_Q = S5; SDM_Q_VALID = 1'b1;
    adc_strobe();
    SDM_Q_VALID = 1'b0;
    tick(30);
    check("t3_hdr", got[0], 64'h5A00_0000_0000_0000);
    pay_chk = rebuild_payload();
    check("t3_slot4", {26'd0, pay_chk[472 +: 38]}, {26'd0, S5});
    check("t3_slot3", {26'd0, pay_chk[434 +: 38]}, {26'd0, S4});

    // Strobe while serializer busy is dropped
    do_reset();
    five_sdm();
    adc_strobe();
    tick(4);
    adc_strobe();
    tick(30);
    check("t4_drop", {48'd0, DROP_CNT}, 64'd1);
    check("t4_full", {63'd0, FIFO_FULL}, 64'd1);
    check("t4_words", 64'(got.size()), 64'd10);

    // Stalled sink fills FIFO: six frames kept, seventh dropped
    do_reset();
    M_AXIS_TREADY = 1'b0;
    for (int i = 0; i < 7; i++) begin
      adc_strobe();
      tick(29);
    end
    check("t5_drop", {48'd0, DROP_CNT}, 64'd1);
    check("t5_full", {63'd0, FIFO_FULL}, 64'd1);
    check("t5_frame_cnt", {32'd0, FRAME_CNT}, 64'd6);
    M_AXIS_TREADY = 1'b1;
    tick(80);
    check("t5_words", 64'(got.size()), 64'd60);
    for (int i = 0; i < 6; i++) begin
      check("t5_hdr_cnt", {32'd0, got[10*i][31:0]}, 64'(i));
      check("t5_hdr_sync", {56'd0, got[10*i][63:56]}, 64'h5A);
    end

    // Reset in the middle of a frame
    do_reset();
    M_AXIS_TREADY = 1'b0;
    five_sdm();
    adc_strobe();
    tick(4);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("t6_tvalid", {63'd0, M_AXIS_TVALID}, 64'd0);
    check("t6_tdata", M_AXIS_TDATA, 64'd0);
    check("t6_frame_cnt", {32'd0, FRAME_CNT}, 64'd0);
    check("t6_drop", {48'd0, DROP_CNT}, 64'd0);
    got.delete();
    M_AXIS_TREADY = 1'b1;
    five_sdm();
    adc_strobe();
    tick(20);
    check("t6_words", 64'(got.size()), 64'd10);
    check("t6_hdr", got[0], 64'h5A00_0000_0000_0000);

    // ENABLE low ignores strobe; dropping ENABLE mid-frame still completes it
    do_reset();
    ENABLE = 1'b0;
    adc_strobe();
    tick(15);
    check("t7_drop", {48'd0, DROP_CNT}, 64'd0);
    check("t7_words0", 64'(got.size()), 64'd0);
    ENABLE = 1'b1;
    five_sdm();
    adc_strobe();
    tick(2);
    ENABLE = 1'b0;
    tick(20);
    check("t7_words", 64'(got.size()), 64'd10);
    check("t7_frame_cnt", {32'd0, FRAME_CNT}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
